// File: rtl/mem_burst_adapter.sv
// mem_burst_adapter
//   Turns the cache's burst master port into single-word accesses on a
//   non-burst memory slave.
//   - Write bursts pass through beat by beat with zero added latency; the
//     beat address is generated locally after the first beat.
//   - Read bursts are accepted immediately and re-issued as pipelined single
//     reads, with at most MAX_PENDING reads outstanding on m0.
//
// Parameters
//   MAX_PENDING  maximum m0 reads issued and not yet returned (1..15)
//
// Ports
//   clk                    clock, rising edge
//   rest                   synchronous active-low reset
//   s0_*                   burst slave port facing the cache
//                          (address, byteEnable, read, write, writeData,
//                           beginBurstTransfer, burstCount, readData,
//                           readDataValid, waitRequest)
//   m0_*                   single-word master port facing the memory
//                          (address, byteEnable, read, write, writeData,
//                           readData, readDataValid, waitRequest)
//
// Build option
//   MEM_BURST_ADAPTER_RDATA_REG_EN  when defined, s0_readData/s0_readDataValid
//   are registered from m0 (one extra cycle of return latency). When not
//   defined they are a combinational pass-through.
module mem_burst_adapter #(
  parameter int MAX_PENDING = 4
) (
  input  logic        clk,
  input  logic        rest,
  input  logic [31:0] s0_address,
  input  logic [3:0]  s0_byteEnable,
  input  logic        s0_read,
  input  logic        s0_write,
  input  logic [31:0] s0_writeData,
  input  logic        s0_beginBurstTransfer,
  input  logic [7:0]  s0_burstCount,
  output logic [31:0] s0_readData,
  output logic        s0_readDataValid,
  output logic        s0_waitRequest,
  output logic [31:0] m0_address,
  output logic [3:0]  m0_byteEnable,
  output logic        m0_read,
  output logic        m0_write,
  output logic [31:0] m0_writeData,
  input  logic [31:0] m0_readData,
  input  logic        m0_readDataValid,
  input  logic        m0_waitRequest
);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

  localparam logic [3:0] MAX_P = 4'(MAX_PENDING);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  remain_q, remain_d;
  logic [3:0]  pending_q, pending_d;
  logic [3:0]  be_q, be_d;
  logic        m0_read_q, m0_read_d;

  logic [7:0]  count;
  logic        rd_accept;
  logic        rd_return;
  logic        wr_accept;
  logic        rd_exit;

  // The first-beat marker carries no information the adapter needs.
  logic unused_ok;
  assign unused_ok = &{1'b0, s0_beginBurstTransfer};

  // A burst count of zero is handled as a single beat.
  assign count     = (s0_burstCount == 8'd0) ? 8'd1 : s0_burstCount;
  assign rd_accept = (state_q == RD_BURST) && m0_read_q && !m0_waitRequest;
  // Returns with nothing outstanding (e.g. late words after a reset) are dropped.
  assign rd_return = m0_readDataValid && (pending_q != 4'd0);
  assign wr_accept = s0_write && !m0_waitRequest;

`ifdef MEM_BURST_ADAPTER_RDATA_REG_EN
  logic [31:0] s0_rdata_q;
  logic        s0_rdv_q;

  // Leave only once the registered copy of the last word has been shown.
  assign rd_exit = (remain_q == 8'd0) && (pending_q == 4'd0);

  always_ff @(posedge clk) begin
    if (!rest) begin
      s0_rdata_q <= '0;
      s0_rdv_q   <= 1'b0;
    end else begin
      s0_rdv_q <= rd_return;
      if (rd_return) begin
        s0_rdata_q <= m0_readData;
      end
    end
  end

  assign s0_readData      = rest ? s0_rdata_q : '0;
  assign s0_readDataValid = rest && s0_rdv_q;
`else
  assign rd_exit = (remain_d == 8'd0) && (pending_d == 4'd0);

  assign s0_readData      = rest ? m0_readData : '0;
  assign s0_readDataValid = rest && rd_return;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    pending_d = pending_q;
    be_d      = be_q;
    m0_read_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (s0_write) begin
          // First beat goes straight through; only multi-beat bursts need state.
          if (!m0_waitRequest && (count > 8'd1)) begin
            addr_d   = s0_address + 32'd4;
            remain_d = count - 8'd1;
            state_d  = WR_BURST;
          end
        end else if (s0_read) begin
          addr_d    = s0_address;
          be_d      = s0_byteEnable;
          remain_d  = count;
          pending_d = 4'd0;
          m0_read_d = 1'b1;
          state_d   = RD_BURST;
        end
      end
      WR_BURST: begin
        if (wr_accept) begin
          addr_d   = addr_q + 32'd4;
          remain_d = remain_q - 8'd1;
          if (remain_q == 8'd1) begin
            state_d = IDLE;
          end
        end
      end
      RD_BURST: begin
        if (rd_accept) begin
          addr_d   = addr_q + 32'd4;
          remain_d = remain_q - 8'd1;
        end
        pending_d = pending_q + 4'(rd_accept) - 4'(rd_return);
        if (rd_exit) begin
          state_d = IDLE;
        end else begin
          // Throttle on the post-edge outstanding count so the limit is never exceeded.
          m0_read_d = (remain_d != 8'd0) && (pending_d < MAX_P);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rest) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      remain_q  <= '0;
      pending_q <= '0;
      be_q      <= '0;
      m0_read_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      remain_q  <= remain_d;
      pending_q <= pending_d;
      be_q      <= be_d;
      m0_read_q <= m0_read_d;
    end
  end

  // Write path is combinational (zero latency); read path drives registered values.
  always_comb begin
    s0_waitRequest = 1'b1;
    m0_address     = '0;
    m0_byteEnable  = '0;
    m0_read        = 1'b0;
    m0_write       = 1'b0;
    m0_writeData   = s0_writeData;
    if (rest) begin
      case (state_q)
        IDLE: begin
          m0_address     = s0_address;
          m0_byteEnable  = s0_byteEnable;
          m0_write       = s0_write;
          s0_waitRequest = s0_write ? m0_waitRequest : 1'b0;
        end
        WR_BURST: begin
          m0_address     = addr_q;
          m0_byteEnable  = s0_byteEnable;
          m0_write       = s0_write;
          s0_waitRequest = m0_waitRequest;
        end
        RD_BURST: begin
          m0_address     = addr_q;
          m0_byteEnable  = be_q;
          m0_read        = m0_read_q;
          s0_waitRequest = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_adapter.sv
module tb_mem_burst_adapter;
  localparam int MAXP = 2;

  logic        clk = 1'b0;
  logic        rest = 1'b0;
  logic [31:0] s0_address = '0;
  logic [3:0]  s0_byteEnable = '0;
  logic        s0_read = 1'b0;
  logic        s0_write = 1'b0;
  logic [31:0] s0_writeData = '0;
  logic        s0_beginBurstTransfer = 1'b0;
  logic [7:0]  s0_burstCount = '0;
  logic [31:0] s0_readData;
  logic        s0_readDataValid;
  logic        s0_waitRequest;
  logic [31:0] m0_address;
  logic [3:0]  m0_byteEnable;
  logic        m0_read;
  logic        m0_write;
  logic [31:0] m0_writeData;
  logic [31:0] m0_readData = '0;
  logic        m0_readDataValid = 1'b0;
  logic        m0_waitRequest = 1'b0;

  mem_burst_adapter #(.MAX_PENDING(MAXP)) dut (
    .clk(clk), .rest(rest),
    .s0_address(s0_address), .s0_byteEnable(s0_byteEnable),
    .s0_read(s0_read), .s0_write(s0_write), .s0_writeData(s0_writeData),
    .s0_beginBurstTransfer(s0_beginBurstTransfer), .s0_burstCount(s0_burstCount),
    .s0_readData(s0_readData), .s0_readDataValid(s0_readDataValid),
    .s0_waitRequest(s0_waitRequest),
    .m0_address(m0_address), .m0_byteEnable(m0_byteEnable),
    .m0_read(m0_read), .m0_write(m0_write), .m0_writeData(m0_writeData),
    .m0_readData(m0_readData), .m0_readDataValid(m0_readDataValid),
    .m0_waitRequest(m0_waitRequest)
  );

  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;
  int cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents: unwritten word at byte address a holds a/4.
  logic [31:0] mem [logic [31:0]];
  function automatic logic [31:0] memrd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : {2'b00, a[31:2]};
  endfunction

  logic [35:0] exp_raddr[$];   // {be, addr} of each m0 read the burst must produce
  logic [67:0] exp_wbeat[$];   // {be, data, addr} of each m0 write beat
  logic [31:0] exp_rd[$];      // words s0 must receive, in order
  int          rd_due[$];      // memory return schedule
  logic [31:0] rd_dat[$];
  logic [31:0] acc_addr[$];    // log of accepted m0 read addresses
  int          acc_cyc[$];
  logic [31:0] got_data[$];    // log of words delivered on s0
  int          lat = 1;
  int          out = 0;        // reads outstanding as seen by the adapter
  int          max_out = 0;
  int          wbeats = 0;
  int          stall_at = -1;
  int          stall_done = 0;
  bit          rand_stall = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bad(input string nm, input logic [31:0] act);
    nchk++;
    nerr++;
    $display("FAIL %s: got %h (cycle %0d)", nm, act, cyc);
  endtask

  // Memory slave: drives return data and wait request just after each edge.
  always @(posedge clk) begin
    #1;
    if (rd_due.size() > 0 && rd_due[0] <= cyc) begin
      m0_readDataValid = 1'b1;
      m0_readData      = rd_dat.pop_front();
      void'(rd_due.pop_front());
    end else begin
      m0_readDataValid = 1'b0;
      m0_readData      = $urandom;
    end
    if (stall_at == wbeats && stall_done < 2) begin
      m0_waitRequest = 1'b1;
      stall_done++;
    end else begin
      if (stall_at != wbeats) stall_done = 0;
      m0_waitRequest = rand_stall && ($urandom_range(0, 3) == 0);
    end
  end

  // Per-cycle checker: m0 transfers and s0 returns against the expected queues.
  always @(negedge clk) begin
    logic [35:0] er;
    logic [67:0] ew;
    logic [31:0] old;
    if (!rest) begin
      out = 0;
      exp_raddr.delete();
      exp_rd.delete();
    end else begin
      if (m0_read) chk("outstanding_below_max", 32'(out < MAXP), 32'd1);
      if (m0_read && m0_write) bad("m0_read_and_write", 32'd1);
      if (m0_readDataValid && out > 0) out--;
      if (m0_read && !m0_waitRequest) begin
        acc_addr.push_back(m0_address);
        acc_cyc.push_back(cyc);
        if (exp_raddr.size() == 0) bad("m0_read_unexpected", m0_address);
        else begin
          er = exp_raddr.pop_front();
          chk("m0_read_addr", m0_address, er[31:0]);
          chk("m0_read_be", 32'(m0_byteEnable), 32'(er[35:32]));
        end
        rd_due.push_back(cyc + lat);
        rd_dat.push_back(memrd(m0_address));
        out++;
      end
      if (m0_write && !m0_waitRequest) begin
        wbeats++;
        if (exp_wbeat.size() == 0) bad("m0_write_unexpected", m0_address);
        else begin
          ew = exp_wbeat.pop_front();
          chk("m0_write_addr", m0_address, ew[31:0]);
          chk("m0_write_data", m0_writeData, ew[63:32]);
          chk("m0_write_be", 32'(m0_byteEnable), 32'(ew[67:64]));
        end
        old = memrd(m0_address);
        for (int b = 0; b < 4; b++)
          if (m0_byteEnable[b]) old[b*8 +: 8] = m0_writeData[b*8 +: 8];
        mem[m0_address] = old;
      end
      if (s0_readDataValid) begin
        got_data.push_back(s0_readData);
        if (exp_rd.size() == 0) bad("s0_readDataValid_unexpected", s0_readData);
        else chk("s0_readData", s0_readData, exp_rd.pop_front());
      end
      if (out > max_out) max_out = out;
    end
  end

  task automatic chk_reset_vals();
    chk("rst_s0_waitRequest", 32'(s0_waitRequest), 32'd1);
    chk("rst_m0_read", 32'(m0_read), 32'd0);
    chk("rst_m0_write", 32'(m0_write), 32'd0);
    chk("rst_m0_address", m0_address, 32'd0);
    chk("rst_m0_byteEnable", 32'(m0_byteEnable), 32'd0);
    chk("rst_s0_readDataValid", 32'(s0_readDataValid), 32'd0);
    chk("rst_s0_readData", s0_readData, 32'd0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] c, input logic [3:0] be,
                         input bit wait_done);
    int n;
    int got;
    int t;
    n   = (c == 8'd0) ? 1 : int'(c);
    got = 0;
    t   = 0;
    @(posedge clk); #2;
    s0_read = 1'b1; s0_address = a; s0_burstCount = c; s0_byteEnable = be;
    s0_beginBurstTransfer = 1'b1;
    @(negedge clk);
    while (s0_waitRequest && t < 50) begin t++; @(negedge clk); end
    if (s0_waitRequest) bad("read_accept_timeout", a);
    for (int i = 0; i < n; i++) begin
      exp_raddr.push_back({be, a + 32'(4 * i)});
      exp_rd.push_back(memrd(a + 32'(4 * i)));
    end
    @(posedge clk); #2;
    s0_read = 1'b0; s0_beginBurstTransfer = 1'b0;
    s0_address = $urandom; s0_burstCount = 8'($urandom); s0_byteEnable = 4'($urandom);
    @(negedge clk);
    chk("first_m0_read_next_cycle", 32'(m0_read), 32'd1);
    chk("first_m0_address", m0_address, a);
    if (s0_readDataValid) got++;
    if (wait_done) begin
      t = 0;
      while (got < n && t < 2000) begin
        @(negedge clk);
        t++;
        if (s0_readDataValid) got++;
      end
      if (got < n) bad("read_done_timeout", 32'(got));
      @(negedge clk);
      chk("idle_after_last_word", 32'(s0_waitRequest), 32'd0);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] c, input logic [31:0] d0,
                          input logic [3:0] be, input bit gaps, output int stalls);
    int n;
    int t;
    n = (c == 8'd0) ? 1 : int'(c);
    stalls = 0;
    for (int i = 0; i < n; i++) exp_wbeat.push_back({be, d0 + 32'(i), a + 32'(4 * i)});
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
      if (gaps && $urandom_range(0, 3) == 0) begin
        s0_write = 1'b0;
        @(posedge clk); #2;
      end
      s0_write = 1'b1; s0_writeData = d0 + 32'(i); s0_byteEnable = be;
      s0_address    = (i == 0) ? a : $urandom;
      s0_burstCount = (i == 0) ? c : 8'($urandom);
      s0_beginBurstTransfer = (i == 0);
      t = 0;
      @(negedge clk);
      while (s0_waitRequest && t < 100) begin stalls++; t++; @(negedge clk); end
      if (s0_waitRequest) bad("write_beat_timeout", 32'(i));
    end
    @(posedge clk); #2;
    s0_write = 1'b0; s0_beginBurstTransfer = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int g;
    int st;
    int t;
    logic [31:0] w;
    logic [31:0] ra;
    logic [7:0]  rc;

    // Reset with busy-looking inputs: every output must still show its reset value.
    s0_write = 1'b1; s0_read = 1'b1; s0_address = 32'h1234_5678; s0_byteEnable = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk); #2;
    s0_write = 1'b0; s0_read = 1'b0;
    @(posedge clk); #2;
    rest = 1'b1;
    @(negedge clk);
    chk("waitRequest_low_after_reset", 32'(s0_waitRequest), 32'd0);

    // 8-beat read, latency 1: one m0 read per cycle, words 0x40..0x47.
    lat = 1;
    b = acc_addr.size(); g = got_data.size();
    do_read(32'h100, 8'd8, 4'hF, 1'b1);
    chk("rd8_accept_count", 32'(acc_addr.size() - b), 32'd8);
    chk("rd8_back_to_back", 32'(acc_cyc[b + 7] - acc_cyc[b]), 32'd7);
    chk("rd8_first_word", got_data[g], 32'h40);
    chk("rd8_last_word", got_data[g + 7], 32'h47);
    chk("rd8_max_outstanding", 32'(max_out), 32'd1);

    // 4-beat write, second beat stalled for exactly 2 cycles.
    stall_at = wbeats + 1;
    do_write(32'h200, 8'd4, 32'hA0, 4'h3, 1'b0, st);
    stall_at = -1;
    chk("wr4_stall_cycles", 32'(st), 32'd2);
    for (int i = 0; i < 4; i++) begin
      w = memrd(32'h200 + 32'(4 * i));
      chk("wr4_mem_low_half", {16'h0, w[15:0]}, 32'hA0 + 32'(i));
    end

    // Address wrap across the top of the 32-bit space.
    b = acc_addr.size();
    do_read(32'hFFFF_FFF8, 8'd4, 4'hF, 1'b1);
    chk("wrap_addr0", acc_addr[b], 32'hFFFF_FFF8);
    chk("wrap_addr1", acc_addr[b + 1], 32'hFFFF_FFFC);
    chk("wrap_addr2", acc_addr[b + 2], 32'h0000_0000);
    chk("wrap_addr3", acc_addr[b + 3], 32'h0000_0004);

    // Count 0 behaves as a single beat.
    b = acc_addr.size(); g = got_data.size();
    do_read(32'h40, 8'd0, 4'hF, 1'b1);
    chk("cnt0_accept_count", 32'(acc_addr.size() - b), 32'd1);
    chk("cnt0_valid_count", 32'(got_data.size() - g), 32'd1);
    chk("cnt0_word", got_data[g], 32'h10);

    // Latency 5 with MAX_PENDING=2: throttled to exactly two outstanding.
    lat = 5;
    g = got_data.size();
    do_read(32'h300, 8'd6, 4'h5, 1'b1);
    chk("lat5_max_outstanding", 32'(max_out), 32'd2);
    chk("lat5_valid_count", 32'(got_data.size() - g), 32'd6);
    chk("lat5_last_word", got_data[g + 5], 32'hC5);

    // Reset after three beats of an 8-beat read.
    b = acc_addr.size();
    do_read(32'h400, 8'd8, 4'hF, 1'b0);
    t = 0;
    while (acc_addr.size() - b < 3 && t < 200) begin @(negedge clk); t++; end
    if (acc_addr.size() - b < 3) bad("reset_test_accept_timeout", 32'(acc_addr.size() - b));
    @(posedge clk); #2;
    rest = 1'b0; s0_write = 1'b1; s0_read = 1'b1; s0_address = 32'hDEAD_BEE0;
    @(negedge clk);
    chk_reset_vals();
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk); #2;
    s0_write = 1'b0; s0_read = 1'b0; rest = 1'b1;
    g = got_data.size();
    t = 0;
    while (rd_due.size() > 0 && t < 100) begin @(negedge clk); t++; end
    @(negedge clk);
    chk("late_return_dropped", 32'(got_data.size() - g), 32'd0);
    lat = 1;
    g = got_data.size();
    do_read(32'h0, 8'd2, 4'hF, 1'b1);
    chk("post_reset_word0", got_data[g], 32'h0);
    chk("post_reset_word1", got_data[g + 1], 32'h1);

    // Random bursts with random memory stalls, latency and write gaps.
    rand_stall = 1'b1;
    for (int k = 0; k < 30; k++) begin
      lat = $urandom_range(1, 6);
      if ($urandom_range(0, 1) == 0) ra = 32'h1000 + 32'(4 * $urandom_range(0, 31));
      else if ($urandom_range(0, 3) == 0) ra = 32'hFFFF_FFF0;
      else ra = $urandom & 32'hFFFF_FFFC;
      rc = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 1) == 0) do_read(ra, rc, 4'($urandom), 1'b1);
      else do_write(ra, rc, $urandom, 4'($urandom), 1'b1, st);
    end
    rand_stall = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_reads_left_over", 32'(exp_rd.size()), 32'd0);
    chk("no_writes_left_over", 32'(exp_wbeat.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/mem_burst_adapter.md
# mem_burst_adapter

Converts the cache's burst master port (address, burstCount, beginBurstTransfer) into a stream of single-word accesses on a non-burst memory slave such as the SDRAM simulation model or controller. It sits directly downstream of the cache's m0 port and directly upstream of the memory. Read bursts are issued as pipelined single reads, with a bounded number outstanding. Write bursts are forwarded beat-by-beat with a generated address.

## Interface
Parameters:
- MAX_PENDING, 4: maximum reads issued to m0 and not yet returned (1..15)

Ports:
- clk  in  1  clock, all logic on rising edge
- rest  in  1  reset; one clock; reset is synchronous and active-low
- s0_address  in  32  burst start byte address, word aligned
- s0_byteEnable  in  4  byte enables, forwarded per beat
- s0_read  in  1  read burst request
- s0_write  in  1  write beat valid
- s0_writeData  in  32  write beat data
- s0_beginBurstTransfer  in  1  first-beat marker, informational only
- s0_burstCount  in  8  beats in burst, sampled at acceptance; 0 treated as 1
- s0_readData  out  32  returned read word
- s0_readDataValid  out  1  s0_readData valid
- s0_waitRequest  out  1  stall toward cache
- m0_address  out  32  single-word address
- m0_byteEnable  out  4  byte enables
- m0_read  out  1  single read
- m0_write  out  1  single write
- m0_writeData  out  32  write data
- m0_readData  in  32  memory read data
- m0_readDataValid  in  1  memory read data valid
- m0_waitRequest  in  1  memory stall

## Operation
- States: IDLE, RD_BURST, WR_BURST. Registers: addr(32), remain(8), pending(4), be(4).
- IDLE:
  - If s0_write: m0_write=1, m0_address=s0_address, and byteEnable/writeData pass through; s0_waitRequest=m0_waitRequest. On accept (!m0_waitRequest): if count>1, addr=s0_address+4, remain=count-1, go WR_BURST; otherwise stay in IDLE.
  - Else if s0_read: s0_waitRequest=0 and the request is accepted. Latch addr=s0_address, be=s0_byteEnable, remain=count. Go RD_BURST.
  - s0_read and s0_write together: treated as write; read ignored.
- WR_BURST:
  - m0_address=addr, m0_write=s0_write, data/byteEnable pass through; s0_waitRequest=m0_waitRequest.
  - Each accepted beat: addr+=4, remain-=1. remain reaching 0 returns to IDLE.
  - s0_write low only idles m0; it does not abort the burst.
- RD_BURST:
  - s0_waitRequest=1. m0_read, m0_address and m0_byteEnable are registered.
  - m0_read=1 while remain>0 and pending<MAX_PENDING.
  - Each m0 accept: addr+=4, remain-=1, pending+=1. Each m0_readDataValid with pending>0: pending-=1 and the word is forwarded to s0.
  - Accept and return in the same cycle: pending is unchanged.
  - Return to IDLE when remain==0 and pending==0.
- Address arithmetic: 32-bit modulo, so 0xFFFFFFFC+4 wraps to 0x00000000. Bits [1:0] are forwarded unchanged.
- m0_readDataValid with pending==0 is dropped.
- Reset mid-operation: state IDLE, counters 0. Late returns are dropped by the rule above.

## Timing
- Reset values (while rest=0):
  - s0_waitRequest=1
  - m0_read=0, m0_write=0
  - m0_address=0, m0_byteEnable=0
  - s0_readDataValid=0, s0_readData=0
- s0_waitRequest goes low the first cycle after rest rises.
- Read: acceptance at edge N, first m0_read visible after edge N, i.e. in cycle N+1.
- With m0_waitRequest=0 and pending not full, one m0 read per cycle.
- Write: zero added latency; one beat per cycle when m0_waitRequest=0.
- After the last read return, the cycle following that edge is IDLE and can accept a new request.

## Configuration
- MEM_BURST_ADAPTER_RDATA_REG_EN defined: s0_readData and s0_readDataValid are registered from m0. This adds one cycle of return latency. Exit from RD_BURST waits for the registered last word to be presented.
- Not defined: combinational pass-through. s0_readData=m0_readData; s0_readDataValid=m0_readDataValid&&(pending>0).

## Test plan
- Read burst, address 0x100, count 8, memory latency 1, memory word[i]=i → m0 reads at 0x100..0x11C, one per cycle. s0 gets 8 valids with data 0x40..0x47 in order, then returns to IDLE.
- Write burst, address 0x200, count 4, data 0xA0..0xA3, byteEnable 0x3. m0_waitRequest high on the 2nd beat for 2 cycles → s0 stalled exactly 2 cycles. Memory at 0x200..0x20C holds low halves 0xA0..0xA3.
- Wrap: read at 0xFFFFFFF8, count 4 → m0 addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- Count 0 read at 0x40 → exactly one m0 read and one s0_readDataValid.
- MAX_PENDING=2, memory latency 5, read count 6 → m0_read never has more than 2 reads outstanding, and all 6 words are returned in order.
- Reset after 3 beats of an 8-beat read burst → outputs take reset values. The next returning m0_readDataValid produces no s0_readDataValid, and a fresh read at 0x0 count 2 completes correctly.
